// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin front end sharing one binary (Stein) GCD engine.
// Ports: clk, rst (sync, active-high); req/a_in/b_in per requester;
//   ack/done one-cycle pulses per requester; ans result (held); busy.
// Optional: GCD_ITER_COUNT_EN adds iter_cnt[7:0] (modifying REDUCE steps).
module gcd_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      ans,
  output logic                  busy
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [7:0]            iter_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    RESTORE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]  u_q, u_d;
  logic [WIDTH-1:0]  v_q, v_d;
  logic [KW-1:0]     k_q, k_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  ans_q, ans_d;
  logic              busy_q, busy_d;
`ifdef GCD_ITER_COUNT_EN
  logic [7:0]        iter_q, iter_d;
`endif

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_arr[g] = a_in[g*WIDTH +: WIDTH];
    assign b_arr[g] = b_in[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] win_nxt;
  int            cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_nxt   = '0;
    cand      = 0;
    for (int j = 0; j < NREQ; j++) begin
      cand = (int'(rr_ptr_q) + j) % NREQ;
      if (!win_found && req[PW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
        win_nxt   = PW'((cand + 1) % NREQ);
      end
    end
  end

  logic [WIDTH-1:0] cap_a, cap_b;
  logic             u_odd, v_odd, uv_eq;

  assign cap_a = a_arr[win_idx];
  assign cap_b = b_arr[win_idx];
  assign u_odd = u_q[0];
  assign v_odd = v_q[0];
  assign uv_eq = (u_q == v_q);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    u_d      = u_q;
    v_d      = v_q;
    k_d      = k_q;
    ack_d    = '0;
    done_d   = '0;
    ans_d    = ans_q;
    busy_d   = busy_q;
`ifdef GCD_ITER_COUNT_EN
    iter_d   = iter_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          u_d            = cap_a;
          v_d            = cap_b;
          k_d            = '0;
          owner_d        = win_idx;
          rr_ptr_d       = win_nxt;
          ack_d[win_idx] = 1'b1;
          busy_d         = 1'b1;
`ifdef GCD_ITER_COUNT_EN
          iter_d         = '0;
`endif
          // gcd(0,x)=x and gcd(0,0)=0 both reduce to a|b.
          if (cap_a == '0 || cap_b == '0) begin
            ans_d           = cap_a | cap_b;
            done_d[win_idx] = 1'b1;
            state_d         = DONE;
          end else begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
`ifdef GCD_ITER_COUNT_EN
        if (!uv_eq) iter_d = iter_q + 8'd1;
`endif
        unique case (1'b1)
          uv_eq: state_d = RESTORE;
          (!uv_eq && !u_odd && !v_odd): begin
            u_d = u_q >> 1;
            v_d = v_q >> 1;
            k_d = k_q + KW'(1);
          end
          (!uv_eq && !u_odd && v_odd): u_d = u_q >> 1;
          (!uv_eq && u_odd && !v_odd): v_d = v_q >> 1;
          (!uv_eq && u_odd && v_odd): begin
            if (u_q > v_q) u_d = (u_q - v_q) >> 1;
            else           v_d = (v_q - u_q) >> 1;
          end
          default: state_d = REDUCE;
        endcase
      end
      RESTORE: begin
        ans_d           = u_q << k_q;
        done_d[owner_q] = 1'b1;
        state_d         = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      u_q      <= '0;
      v_q      <= '0;
      k_q      <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      ans_q    <= '0;
      busy_q   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      iter_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      u_q      <= u_d;
      v_q      <= v_d;
      k_q      <= k_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      ans_q    <= ans_d;
      busy_q   <= busy_d;
`ifdef GCD_ITER_COUNT_EN
      iter_q   <= iter_d;
`endif
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign ans  = ans_q;
  assign busy = busy_q;
`ifdef GCD_ITER_COUNT_EN
  assign iter_cnt = iter_q;
`endif

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed table plus hand sequences for gcd_scheduler.
// Covers reset, edge operands, round-robin, mid-op reset and hold-off.
module tb_gcd_scheduler;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic [W-1:0]   ans;
  logic           busy;
`ifdef GCD_ITER_COUNT_EN
  logic [7:0]     iter_cnt;
`endif

  gcd_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a_in (a_in),
    .b_in (b_in),
    .ack  (ack),
    .done (done),
    .ans  (ans),
    .busy (busy)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_cnt (iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_ans;
    int         exp_iter;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int id, input logic [7:0] a,
                         input logic [7:0] b);
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
  endtask

  task automatic wait_ack(input logic [N-1:0] exp, input string nm,
                          output int cyc);
    cyc = 0;
    while (ack == '0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk({nm, " ack"}, 32'(ack), 32'(exp));
  endtask

  task automatic wait_done(input int id, input logic [7:0] exp_ans,
                           input int exp_iter, input string nm,
                           output int cyc);
    cyc = 0;
    while (done == '0 && cyc < 40) begin
      step();
      cyc++;
      if (done == '0) chk({nm, " busy_mid"}, 32'(busy), 32'd1);
    end
    chk({nm, " done"}, 32'(done), 32'(1 << id));
    chk({nm, " ans"}, 32'(ans), 32'(exp_ans));
    chk({nm, " busy_done"}, 32'(busy), 32'd1);
`ifdef GCD_ITER_COUNT_EN
    if (exp_iter >= 0) chk({nm, " iter"}, 32'(iter_cnt), 32'(exp_iter));
`endif
    step();
    chk({nm, " busy_after"}, 32'(busy), 32'd0);
    chk({nm, " done_after"}, 32'(done), 32'd0);
    chk({nm, " ans_hold"}, 32'(ans), 32'(exp_ans));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vecs [8];
  int   ca, cd;

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    @(negedge clk);
    step();
    step();
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ans", 32'(ans), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // latency = cycles from request edge to done visible (ack = 1)
    vecs[0] = '{0, 8'd48,  8'd18,  8'd6,   5, 8};
    vecs[1] = '{1, 8'd0,   8'd35,  8'd35,  0, 1};
    vecs[2] = '{2, 8'd0,   8'd0,   8'd0,   0, 1};
    vecs[3] = '{3, 8'd255, 8'd255, 8'd255, 0, 3};
    vecs[4] = '{0, 8'd128, 8'd64,  8'd64,  7, 10};
    vecs[5] = '{1, 8'd251, 8'd241, 8'd1,   8, 11};
    vecs[6] = '{2, 8'd35,  8'd0,   8'd35,  0, 1};
    vecs[7] = '{3, 8'd36,  8'd24,  8'd12,  4, 7};

    for (int i = 0; i < 8; i++) begin
      set_ops(vecs[i].id, vecs[i].a, vecs[i].b);
      req[vecs[i].id] = 1'b1;
      wait_ack(N'(1 << vecs[i].id), $sformatf("vec%0d", i), ca);
      chk($sformatf("vec%0d ack_lat", i), 32'(ca), 32'd1);
      req[vecs[i].id] = 1'b0;
      wait_done(vecs[i].id, vecs[i].exp_ans, vecs[i].exp_iter,
                $sformatf("vec%0d", i), cd);
      chk($sformatf("vec%0d lat", i), 32'(cd + 1),
          32'(vecs[i].exp_lat));
    end

    // Round-robin from reset: 0 then 2, then pointer at 3.
    do_reset();
    set_ops(0, 8'd48, 8'd18);
    set_ops(2, 8'd21, 8'd14);
    req = 4'b0101;
    wait_ack(4'b0001, "rr0", ca);
    req[0] = 1'b0;
    wait_done(0, 8'd6, 5, "rr0", cd);
    wait_ack(4'b0100, "rr2", ca);
    chk("rr2 gap", 32'(ca), 32'd1);
    req[2] = 1'b0;
    wait_done(2, 8'd7, 2, "rr2", cd);
    set_ops(0, 8'd36, 8'd24);
    set_ops(3, 8'd0, 8'd35);
    req = 4'b1001;
    wait_ack(4'b1000, "rr3", ca);
    req[3] = 1'b0;
    wait_done(3, 8'd35, 0, "rr3", cd);
    chk("rr3 shortcut", 32'(cd), 32'd0);
    wait_ack(4'b0001, "rr0b", ca);
    chk("rr0b gap", 32'(ca), 32'd1);
    req[0] = 1'b0;
    wait_done(0, 8'd12, 4, "rr0b", cd);

    // Reset mid-op aborts; held request is re-accepted.
    set_ops(1, 8'd251, 8'd241);
    req[1] = 1'b1;
    wait_ack(4'b0010, "mid", ca);
    step();
    step();
    chk("mid pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid rst ack", 32'(ack), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst ans", 32'(ans), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("mid reacc", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    wait_done(1, 8'd1, 8, "mid", cd);
    chk("mid lat", 32'(cd + 1), 32'd11);

    // Hold-off: operands changed after ack are ignored.
    set_ops(0, 8'd48, 8'd18);
    req[0] = 1'b1;
    wait_ack(4'b0001, "hold0", ca);
    req[0] = 1'b0;
    set_ops(0, 8'd100, 8'd75);
    set_ops(2, 8'd21, 8'd14);
    req[2] = 1'b1;
    wait_done(0, 8'd6, 5, "hold0", cd);
    wait_ack(4'b0100, "hold2", ca);
    chk("hold2 gap", 32'(ca), 32'd1);
    req[2] = 1'b0;
    wait_done(2, 8'd7, 2, "hold2", cd);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
Name: gcd_scheduler

Overview:
Shares one iterative binary-GCD (Stein) engine between NREQ requesters. Arbitrates round-robin, captures the winner's operands, and runs the reduce and shift-back sequence one step per clock. It returns the result with a per-requester done pulse. Sits between the arithmetic clients and the GCD datapath, replacing a single-shot, unsequenced GCD.

Parameters:
WIDTH, 8, operand/result width in bits
NREQ, 4, number of requesters (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  NREQ  request per requester; held high until its ack
a_in  input  NREQ*WIDTH  operand a; slice i belongs to requester i
b_in  input  NREQ*WIDTH  operand b; slice i belongs to requester i
ack  output  NREQ  one-cycle pulse; request i accepted, operands captured
done  output  NREQ  one-cycle pulse; ans is valid for requester i
ans  output  WIDTH  result; held until the next done
busy  output  1  high from acceptance through the done cycle

Behaviour:
- One clock: clk. Reset is synchronous, active-high, named rst. All outputs are registered.
- Reset values: ack=0, done=0, ans=0, busy=0, state=IDLE, rr_ptr=0, k=0, u=v=0.
- Reset mid-operation: the operation is aborted with no done pulse. A request still held after reset is re-arbitrated normally.
- States: IDLE, REDUCE, RESTORE, DONE.
- IDLE
  - If any req is high, the winner is the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping mod NREQ.
  - On the edge: capture u=a_in[i] and v=b_in[i], k=0, owner=i, rr_ptr=(i+1) mod NREQ.
  - ack[i]=1 for the next cycle only; busy=1.
  - If u==0 or v==0: ans=u|v, go to DONE, skipping REDUCE. Otherwise go to REDUCE.
- REDUCE: one step per cycle, priority order:
  - u==v: go to RESTORE, no change.
  - both even: u>>=1, v>>=1, k+=1.
  - u even: u>>=1.
  - v even: v>>=1.
  - both odd: if u>v then u=(u-v)>>1, else v=(v-u)>>1.
- REDUCE invariants and limits:
  - The subtraction never underflows; u and v never reach 0.
  - k is clog2(WIDTH)+1 bits; k never exceeds WIDTH-1.
  - Bounded at 2*WIDTH steps.
- RESTORE: ans = u << k, truncated to WIDTH, which is lossless. Go to DONE.
- DONE: done[owner]=1 for one cycle; busy=0 on the next cycle; go to IDLE.
  - A new request can be accepted in the IDLE cycle immediately after DONE.
- Request handling:
  - Requests arriving while busy are held off, not lost; the requester keeps req high.
  - Operands are sampled only on the accepting edge; later changes to a_in/b_in are ignored.
  - A requester may reassert req the cycle after its done. Fairness guarantees no starvation: worst-case wait is NREQ-1 operations.
- Simultaneous rst and req: rst wins and nothing is accepted.
- Result definitions: gcd(0,0)=0; gcd(0,x)=x.

Optional Feature:
GCD_ITER_COUNT_EN
- Defined: adds output iter_cnt, 8 bits. It counts REDUCE cycles that modified u or v (excluding the final u==v cycle). Cleared on accept, valid and held from the done cycle, reset to 0. It is 0 for zero-operand shortcuts.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single requester: req[0] with a=48, b=18 → ack[0] pulse 1 cycle later, then done[0] pulse with ans=6, busy high from ack through done, and rr_ptr=1 after accept.
- Zero and edge operands:
  - (0,35) → ans=35 via IDLE→DONE with no REDUCE cycles.
  - (0,0) → ans=0.
  - (255,255) → ans=255.
  - (128,64) → ans=64.
  - (251,241) → ans=1.
- Round-robin:
  - From reset, req[0] and req[2] together → requester 0 served first, then requester 2 with no idle gap beyond DONE→IDLE; rr_ptr=3.
  - Next, req[0] and req[3] together → requester 3 is acked first.
- Reset mid-op: req[1] with (251,241), assert rst for 1 cycle during REDUCE → next cycle all outputs 0 and no done[1]. With req[1] still high, it is re-accepted and finishes with ans=1.
- Hold-off: req[2] raised while requester 0 is busy, with a_in/b_in of requester 0 changed after ack → requester 0 still gets the result of its captured operands; requester 2 is acked the cycle after done[0]'s IDLE.
- GCD_ITER_COUNT_EN defined: (48,18) → iter_cnt=5 at done, ans=6; (0,7) → iter_cnt=0.
